// File: rtl/comparator_pkg.sv
// Purpose: shared constants and the group-compare helper for the dual-structure comparator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package comparator_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int GRP_W     = 4;

   // Group compare built from per-bit equal/greater terms: a bit position wins
   // "greater" when it is greater and every more significant bit is equal.
   // Returns {eq, gt}.
   function automatic logic [1:0] grp_cmp(input logic [GRP_W-1:0] ga,
                                          input logic [GRP_W-1:0] gb);
      logic [GRP_W-1:0] e;
      logic [GRP_W-1:0] g;
      logic             pre;
      logic             geq;
      logic             ggt;
      e   = ~(ga ^ gb);
      g   = ga & ~gb;
      geq = &e;
      ggt = 1'b0;
      for (int i = 0; i < GRP_W; i++) begin
         pre = 1'b1;
         for (int j = i + 1; j < GRP_W; j++) begin
            pre = pre & e[j];
         end
         ggt = ggt | (g[i] & pre);
      end
      return {geq, ggt};
   endfunction

endpackage

// File: rtl/comparator_cell.sv
// Purpose: one bit of the MSB-to-LSB ripple magnitude comparator.
// Latency: combinational.
// Backpressure: none.
module comparator_cell (
   input  logic eq_i,
   input  logic gt_i,
   input  logic a_i,
   input  logic b_i,
   output logic eq_o,
   output logic gt_o
);

   // Stay equal only while bits match; become greater at the first bit where a wins.
   assign eq_o = eq_i & ~(a_i ^ b_i);
   assign gt_o = gt_i | (eq_i & a_i & ~b_i);

endmodule

// File: rtl/comparator_8bit.sv
// Purpose: registered unsigned compare of a/b using a ripple and a tree structure, flagging disagreement.
// Latency: one cycle; outputs reflect a/b sampled at the previous rising clk edge.
// Backpressure: none; a new compare is accepted every cycle.
module comparator_8bit
   import comparator_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             mismatch
);

   // Ripple structure: chain index WIDTH is the seed, index 0 is the final result.
   logic [WIDTH:0] eq_chain;
   logic [WIDTH:0] gt_chain;

   assign eq_chain[WIDTH] = 1'b1;
   assign gt_chain[WIDTH] = 1'b0;

   for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
      comparator_cell u_cell (
         .eq_i (eq_chain[i+1]),
         .gt_i (gt_chain[i+1]),
         .a_i  (a[i]),
         .b_i  (b[i]),
         .eq_o (eq_chain[i]),
         .gt_o (gt_chain[i])
      );
   end

   logic eq1;
   logic gt1;
   assign eq1 = eq_chain[0];
   assign gt1 = gt_chain[0];

   // Tree structure: independent high and low group compares merged at the top.
   logic [1:0] hi_res;
   logic [1:0] lo_res;
   logic       eq2;
   logic       gt2;

   // Combine the two groups; the high group dominates unless it is equal.
   always_comb begin
      hi_res = grp_cmp(a[WIDTH-1 -: GRP_W], b[WIDTH-1 -: GRP_W]);
      lo_res = grp_cmp(a[GRP_W-1:0], b[GRP_W-1:0]);
      eq2    = hi_res[1] & lo_res[1];
      gt2    = hi_res[0] | (hi_res[1] & lo_res[0]);
   end

   logic eq_d, gt_d, lt_d, mm_d;
   logic eq_q, gt_q, lt_q, mm_q;

   // Next-state: primary result comes from the ripple chain; the tree only feeds the cross-check.
   always_comb begin
      eq_d = eq1;
      gt_d = gt1;
      lt_d = ~eq1 & ~gt1;
      mm_d = ({eq1, gt1} != {eq2, gt2});
   end

   // Output registers, cleared asynchronously while reset is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eq_q <= 1'b0;
         gt_q <= 1'b0;
         lt_q <= 1'b0;
         mm_q <= 1'b0;
      end else begin
         eq_q <= eq_d;
         gt_q <= gt_d;
         lt_q <= lt_d;
         mm_q <= mm_d;
      end
   end

   assign eq       = eq_q;
   assign gt       = gt_q;
   assign lt       = lt_q;
   assign mismatch = mm_q;

endmodule

// File: tb/tb_comparator_8bit.sv
// Purpose: self-checking bench for comparator_8bit (directed table, corner sequences, exhaustive sweep).
// Latency: checks expect results one rising edge after inputs are applied.
// Backpressure: n/a.
module tb_comparator_8bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       eq, gt, lt, mismatch;

   int checks;
   int errors;

   comparator_8bit #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .eq       (eq),
      .gt       (gt),
      .lt       (lt),
      .mismatch (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [3:0] exp; // {eq, gt, lt, mismatch}
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got {eq,gt,lt,mm}=%b expected %b (a=%02h b=%02h t=%0t)",
                  name, act, expv, a, b, $time);
      end
   endtask

   function automatic logic [3:0] ref_cmp(input logic [7:0] ra, input logic [7:0] rb);
      int ia, ib;
      ia = ra;
      ib = rb;
      return {(ia == ib), (ia > ib), (ia < ib), 1'b0};
   endfunction

   // Apply inputs away from the edge, take one rising edge, sample 1 ns later.
   task automatic step(input logic [7:0] sa, input logic [7:0] sb);
      a = sa;
      b = sb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      a      = 8'h5A;
      b      = 8'h00;
      rst_n  = 1'b0;

      // Reset state before any clock edge, then across edges while held.
      #2;
      chk("reset_async", {eq, gt, lt, mismatch}, 4'b0000);
      @(posedge clk);
      #1;
      chk("reset_held_edge", {eq, gt, lt, mismatch}, 4'b0000);

      // Release between edges; the first edge loads the current inputs.
      a = 8'h00;
      b = 8'h00;
      #1 rst_n = 1'b1;
      #1;
      chk("release_no_edge", {eq, gt, lt, mismatch}, 4'b0000);

      vecs.push_back('{8'h00, 8'h00, 4'b1000});
      vecs.push_back('{8'h80, 8'h7F, 4'b0100});
      vecs.push_back('{8'h7F, 8'h80, 4'b0010});
      vecs.push_back('{8'hA5, 8'hA4, 4'b0100});
      vecs.push_back('{8'hA5, 8'hA5, 4'b1000});
      vecs.push_back('{8'h00, 8'hFF, 4'b0010});
      vecs.push_back('{8'hFF, 8'h00, 4'b0100});
      vecs.push_back('{8'hFF, 8'hFF, 4'b1000});
      vecs.push_back('{8'h01, 8'h00, 4'b0100});
      vecs.push_back('{8'h10, 8'h0F, 4'b0100});
      vecs.push_back('{8'h0F, 8'h10, 4'b0010});
      vecs.push_back('{8'h3C, 8'h3D, 4'b0010});
      vecs.push_back('{8'h4B, 8'h4B, 4'b1000});

      foreach (vecs[i]) begin
         step(vecs[i].va, vecs[i].vb);
         chk($sformatf("vec%0d", i), {eq, gt, lt, mismatch}, vecs[i].exp);
      end

      // Hold: a change between edges must not show until the next edge.
      step(8'hA5, 8'hA4);
      chk("hold_gt", {eq, gt, lt, mismatch}, 4'b0100);
      b = 8'hA5;
      #2;
      chk("hold_before_edge", {eq, gt, lt, mismatch}, 4'b0100);
      @(posedge clk);
      #1;
      chk("hold_after_edge", {eq, gt, lt, mismatch}, 4'b1000);

      // Mid-operation reset clears immediately, then recovers on the next edge.
      step(8'h80, 8'h7F);
      chk("pre_reset_gt", {eq, gt, lt, mismatch}, 4'b0100);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_reset_clear", {eq, gt, lt, mismatch}, 4'b0000);
      a = 8'h3C;
      b = 8'h3C;
      #1 rst_n = 1'b1;
      #1;
      chk("mid_release_no_edge", {eq, gt, lt, mismatch}, 4'b0000);
      @(posedge clk);
      #1;
      chk("post_reset_eq", {eq, gt, lt, mismatch}, 4'b1000);

      // Exhaustive sweep against an integer reference.
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib++) begin
            step(ia[7:0], ib[7:0]);
            chk("sweep", {eq, gt, lt, mismatch}, ref_cmp(ia[7:0], ib[7:0]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/comparator_8bit.md
COMPARATOR_8BIT -- requirements
Module: comparator_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; only 8 is supported and verified.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  8  operand A, unsigned.
REQ-005 Port: b  input  8  operand B, unsigned.
REQ-006 Port: eq  output  1  registered flag, 1 when a == b.
REQ-007 Port: gt  output  1  registered flag, 1 when a > b, unsigned.
REQ-008 Port: lt  output  1  registered flag, 1 when a < b, unsigned.
REQ-009 Port: mismatch  output  1  registered flag, 1 when the two internal comparator structures disagree.

Function
REQ-010 The block SHALL contain two independent comparison structures computing (eq, gt) from the same a, b inputs.
REQ-011 Structure 1 (ripple): chain of eight 1-bit cells, MSB to LSB. Each cell takes eq_in/gt_in from the more significant cell and produces eq_out = eq_in & ~(a_i ^ b_i) and gt_out = gt_in | (eq_in & a_i & ~b_i). The MSB cell's chain input is eq_in=1, gt_in=0.
REQ-012 Structure 2 (tree): two 4-bit group comparators, each built from per-bit equal/greater terms. Results are combined as eq = eq_hi & eq_lo and gt = gt_hi | (eq_hi & gt_lo).
REQ-013 The primary result SHALL be taken from structure 1. lt = ~eq & ~gt.
REQ-014 eq, gt and lt SHALL be one-hot for every input pair after the first clock edge out of reset.
REQ-015 Latency: outputs SHALL reflect the a, b values sampled at a rising clk edge from that edge until the next edge (one-cycle latency); no valid/ready handshake.
REQ-016 mismatch SHALL be registered with the same one-cycle latency. Its value is {eq1,gt1} != {eq2,gt2} for the sampled inputs. It is not sticky.
REQ-017 Comparison is unsigned for all inputs. Boundary pairs 0x00/0xFF, 0x80/0x7F and equal operands SHALL follow REQ-006..REQ-008 with no special case.
REQ-018 Inputs that change between edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-019 While rst_n = 0, eq, gt, lt and mismatch SHALL be 0, asynchronously, regardless of clk.
REQ-020 Assertion of rst_n mid-operation SHALL clear all outputs immediately.
REQ-021 After rst_n deasserts, the first rising clk edge SHALL load the result for the current a, b.

Structure
REQ-022 A package comparator_pkg SHALL hold the WIDTH default (8) and the group width constant (4).
REQ-023 The 1-bit cascade cell SHALL be a sub-module named comparator_cell, instantiated eight times in structure 1.
REQ-024 Structure 2 and the output registers SHALL be in the top module. No latches. All combinational logic fully assigned.

Verification
REQ-025 a=0x00, b=0x00, one clk edge -> eq=1, gt=0, lt=0, mismatch=0.
REQ-026 a=0x80, b=0x7F -> after one edge gt=1, eq=0, lt=0. Swapping the operands -> lt=1, gt=0.
REQ-027 a=0xA5, b=0xA4 -> gt=1. Then a=0xA5, b=0xA5 -> eq=1 on the following edge, and the previous value holds until that edge.
REQ-028 Exhaustive sweep of all 65536 (a,b) pairs -> outputs match an integer compare one cycle later, mismatch=0 throughout.
REQ-029 rst_n pulled low between edges while gt=1 -> all outputs 0 immediately. rst_n released with a=b=0x3C -> eq=1 after the next edge.
